// File: rtl/nocif_burst_gen_if.sv
// nocif_burst_gen_if
//   Flit port between a module-side flit source and the NoC interface slave
//   ("from module" side). One flit is transferred on each clock where
//   wrreq=1 and stall=0.
// Signals
//   wrreq      flit valid (source -> NoC)
//   stall      NoC interface back-pressure (NoC -> source)
//   burst      1 on every flit except the last one of a burst
//   arq, bsel, mode, addr                     header fields, held per burst
//   src_modid, src_chipid, trg_modid, trg_chipid  routing IDs, held per burst
//   data0, data1                               flit payload
// Modports: master = flit source, slave = NoC interface.
interface nocif_burst_gen_if #(
  parameter int NOC_DATA_SIZE   = 32,
  parameter int NOC_ADDR_SIZE   = 32,
  parameter int NOC_MODE_SIZE   = 4,
  parameter int NOC_BSEL_SIZE   = 4,
  parameter int NOC_MODID_SIZE  = 12,
  parameter int NOC_CHIPID_SIZE = 6
);
  logic                       wrreq;
  logic                       stall;
  logic                       burst;
  logic                       arq;
  logic [NOC_BSEL_SIZE-1:0]   bsel;
  logic [NOC_MODE_SIZE-1:0]   mode;
  logic [NOC_ADDR_SIZE-1:0]   addr;
  logic [NOC_MODID_SIZE-1:0]  src_modid;
  logic [NOC_CHIPID_SIZE-1:0] src_chipid;
  logic [NOC_MODID_SIZE-1:0]  trg_modid;
  logic [NOC_CHIPID_SIZE-1:0] trg_chipid;
  logic [NOC_DATA_SIZE-1:0]   data0;
  logic [NOC_DATA_SIZE-1:0]   data1;

  modport master (
    output wrreq, burst, arq, bsel, mode, addr,
           src_modid, src_chipid, trg_modid, trg_chipid, data0, data1,
    input  stall
  );

  modport slave (
    input  wrreq, burst, arq, bsel, mode, addr,
           src_modid, src_chipid, trg_modid, trg_chipid, data0, data1,
    output stall
  );
endinterface

// File: rtl/nocif_burst_gen.sv
// nocif_burst_gen
//   Turns one write command (target, mode, addr, flit count) plus a stream of
//   per-flit data words into a framed NoC burst on the flit port.
//   One-deep flit register: a new flit is loaded in the same cycle the
//   current one is taken, so an unstalled burst runs at one flit per cycle.
// Ports
//   clk_i, reset_q_i        clock, synchronous active-low reset
//   own_modid_i/chipid_i    own IDs (static), latched as source IDs per burst
//   cmd_*                   command handshake and fields; cmd_flits_i==0 is illegal
//   dat_valid_i/ready_o/dat_i  per-flit data {data1,data0}; first flit drops data1
//   busy_o                  command in progress
//   cmd_err_o               one-cycle pulse on an illegal (or timed-out) command
//   mod                     flit port (master side of nocif_burst_gen_if)
// Configuration
//   NOCIF_BURST_TIMEOUT_EN  when defined, TIMEOUT cycles without data mid-burst
//                           pad the rest of the burst with zero flits and pulse
//                           cmd_err_o once.
module nocif_burst_gen #(
  parameter int NOC_DATA_SIZE   = 32,
  parameter int NOC_ADDR_SIZE   = 32,
  parameter int NOC_MODE_SIZE   = 4,
  parameter int NOC_BSEL_SIZE   = 4,
  parameter int NOC_MODID_SIZE  = 12,
  parameter int NOC_CHIPID_SIZE = 6,
  parameter int LEN_W           = 8
`ifdef NOCIF_BURST_TIMEOUT_EN
  , parameter int TIMEOUT       = 255
`endif
) (
  input  logic                         clk_i,
  input  logic                         reset_q_i,
  input  logic [NOC_MODID_SIZE-1:0]    own_modid_i,
  input  logic [NOC_CHIPID_SIZE-1:0]   own_chipid_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [NOC_MODID_SIZE-1:0]    cmd_trg_modid_i,
  input  logic [NOC_CHIPID_SIZE-1:0]   cmd_trg_chipid_i,
  input  logic [NOC_MODE_SIZE-1:0]     cmd_mode_i,
  input  logic [NOC_ADDR_SIZE-1:0]     cmd_addr_i,
  input  logic [NOC_BSEL_SIZE-1:0]     cmd_bsel_i,
  input  logic                         cmd_arq_i,
  input  logic [LEN_W-1:0]             cmd_flits_i,
  input  logic                         dat_valid_i,
  output logic                         dat_ready_o,
  input  logic [2*NOC_DATA_SIZE-1:0]   dat_i,
  output logic                         busy_o,
  output logic                         cmd_err_o,
  nocif_burst_gen_if.master            mod
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_LAST} state_e;

  typedef struct packed {
    logic                       arq;
    logic [NOC_BSEL_SIZE-1:0]   bsel;
    logic [NOC_MODE_SIZE-1:0]   mode;
    logic [NOC_ADDR_SIZE-1:0]   addr;
    logic [NOC_MODID_SIZE-1:0]  src_modid;
    logic [NOC_CHIPID_SIZE-1:0] src_chipid;
    logic [NOC_MODID_SIZE-1:0]  trg_modid;
    logic [NOC_CHIPID_SIZE-1:0] trg_chipid;
  } hdr_t;

  state_e                     state_d, state_q;
  logic [LEN_W-1:0]           cnt_d, cnt_q;      // flits still to be loaded
  logic                       first_d, first_q;  // next load is the first flit
  hdr_t                       hdr_d, hdr_q;
  logic                       wrreq_d, wrreq_q;
  logic                       burst_d, burst_q;
  logic [NOC_DATA_SIZE-1:0]   data0_d, data0_q;
  logic [NOC_DATA_SIZE-1:0]   data1_d, data1_q;
  logic                       err_d, err_q;

  logic                       slot_free, take, load, dat_rdy;
  logic [2*NOC_DATA_SIZE-1:0] ld_data;

`ifdef NOCIF_BURST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_d, to_cnt_q;
  logic            pad_d, pad_q;            // padding remaining flits with zeros
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    hdr_d   = hdr_q;
    wrreq_d = wrreq_q;
    burst_d = burst_q;
    data0_d = data0_q;
    data1_d = data1_q;
    err_d   = 1'b0;

    take = wrreq_q && !mod.stall;
    // FR can accept a new flit when empty or emptying this cycle
    slot_free = (state_q == ST_BUSY) && (cnt_q != '0) && (!wrreq_q || !mod.stall);
`ifdef NOCIF_BURST_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    pad_d    = pad_q;
    dat_rdy  = slot_free && !pad_q;
    load     = slot_free && (dat_valid_i || pad_q);
    ld_data  = pad_q ? '0 : dat_i;
`else
    dat_rdy  = slot_free;
    load     = slot_free && dat_valid_i;
    ld_data  = dat_i;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_flits_i == '0) begin
            err_d = 1'b1;
          end else begin
            hdr_d   = '{arq: cmd_arq_i, bsel: cmd_bsel_i, mode: cmd_mode_i,
                        addr: cmd_addr_i, src_modid: own_modid_i,
                        src_chipid: own_chipid_i, trg_modid: cmd_trg_modid_i,
                        trg_chipid: cmd_trg_chipid_i};
            cnt_d   = cmd_flits_i;
            first_d = 1'b1;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (take) wrreq_d = 1'b0;
        // load overrides take: FR refilled in the same cycle, no bubble
        if (load) begin
          wrreq_d = 1'b1;
          burst_d = (cnt_q != LEN_W'(1));
          data0_d = ld_data[NOC_DATA_SIZE-1:0];
          data1_d = first_q ? '0 : ld_data[2*NOC_DATA_SIZE-1:NOC_DATA_SIZE];
          first_d = 1'b0;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (take) begin
          wrreq_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef NOCIF_BURST_TIMEOUT_EN
    // Counts starved cycles (stalled ones included) while flits remain
    if (state_q == ST_IDLE) begin
      to_cnt_d = '0;
      pad_d    = 1'b0;
    end else if (load) begin
      to_cnt_d = '0;
    end else if (state_q == ST_BUSY && cnt_q != '0 && !pad_q) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        to_cnt_d = '0;
        pad_d    = 1'b1;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_q_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      hdr_q    <= '0;
      wrreq_q  <= 1'b0;
      burst_q  <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
      err_q    <= 1'b0;
`ifdef NOCIF_BURST_TIMEOUT_EN
      to_cnt_q <= '0;
      pad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      hdr_q    <= hdr_d;
      wrreq_q  <= wrreq_d;
      burst_q  <= burst_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      err_q    <= err_d;
`ifdef NOCIF_BURST_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      pad_q    <= pad_d;
`endif
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign dat_ready_o    = dat_rdy;
  assign cmd_err_o      = err_q;

  assign mod.wrreq      = wrreq_q;
  assign mod.burst      = burst_q;
  assign mod.data0      = data0_q;
  assign mod.data1      = data1_q;
  assign mod.arq        = hdr_q.arq;
  assign mod.bsel       = hdr_q.bsel;
  assign mod.mode       = hdr_q.mode;
  assign mod.addr       = hdr_q.addr;
  assign mod.src_modid  = hdr_q.src_modid;
  assign mod.src_chipid = hdr_q.src_chipid;
  assign mod.trg_modid  = hdr_q.trg_modid;
  assign mod.trg_chipid = hdr_q.trg_chipid;

endmodule
